// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial stage feeding the "more than one 1 in last 3 samples"
// detector. A WIDTH-bit word is taken on a valid/ready handshake and sent
// out one bit per clock on x. x is held at 0 between frames so the detector
// sees a clean zero stream. Back-to-back words are sent with no gap cycle.
//
// Parameters:
//   WIDTH      data word width, 2..32
//   MSB_FIRST  1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset, released synchronously
//   din         parallel word, held stable until accepted
//   din_valid   upstream presents a word on din
//   din_ready   block accepts a word on this cycle's rising edge
//   x           serial bit to the detector
//   x_valid     x carries a frame bit
//   busy        a frame is in progress
//   frame_done  pulses with the last bit of a frame
//
// Optional feature, macro BIT_SERIALIZER_PARITY_EN:
//   When defined, an even-parity bit (XOR of the word) follows the last data
//   bit, making frames WIDTH+1 cycles long; frame_done and the reload
//   opportunity move to the parity cycle.
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifndef BIT_SERIALIZER_PARITY_EN
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);
`endif

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par;
`endif

    logic last_bit;
    logic accept;
    logic first_bit;
    logic next_bit;

    // x is registered, so the bit shown after a load is taken straight from
    // din, and during shifting the bit one position behind the head of the
    // shift register is the one that goes out next.
    assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];

    // The cycle that shows the final bit of a frame is also a reload slot,
    // which is what lets back-to-back frames run with no bubble.
`ifdef BIT_SERIALIZER_PARITY_EN
    assign last_bit = (state == PARITY);
`else
    assign last_bit = (state == SHIFT) && (cnt == LAST_IDX);
`endif

    assign din_ready = rst && ((state == IDLE) || last_bit);
    assign accept    = din_valid && din_ready;

    // Single FSM with registered outputs. A load always wins; otherwise the
    // frame either advances one bit, moves to the parity bit, or returns to
    // IDLE with x forced back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            shreg      <= din;
            cnt        <= '0;
            x          <= first_bit;
            x_valid    <= 1'b1;
            busy       <= 1'b1;
            frame_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par        <= ^din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (cnt == LAST_IDX) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                        state      <= PARITY;
                        x          <= par;
                        frame_done <= 1'b1;
`else
                        state      <= IDLE;
                        shreg      <= '0;
                        cnt        <= '0;
                        x          <= 1'b0;
                        x_valid    <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
`endif
                    end else begin
                        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        cnt   <= cnt + CW'(1);
                        x     <= next_bit;
`ifdef BIT_SERIALIZER_PARITY_EN
                        frame_done <= 1'b0;
`else
                        frame_done <= (cnt == PENULT_IDX);
`endif
                    end
                end
                default: begin
                    state      <= IDLE;
                    shreg      <= '0;
                    cnt        <= '0;
                    x          <= 1'b0;
                    x_valid    <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the sample-window "more than one 1 in last 3 samples" detector.
- Accepts a WIDTH-bit word on a valid/ready handshake and drives it out one bit per clock on x, the detector's serial input.
- Drives x to 0 when idle, so the detector sees a clean zero stream between frames.
- Supports back-to-back frames with no bubble.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order: 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk. Release is synchronous to clk.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  upstream has a word on din. din must stay stable while din_valid=1 and din_ready=0.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit; feeds the detector's x input.
- x_valid  output  1  x carries a frame bit this cycle.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Reset (rst=0), all asynchronous:
  - state=IDLE, shift register=0, bit counter=0.
  - x=0, x_valid=0, busy=0, frame_done=0.
  - din_ready=0 while rst=0.
- din_ready is combinational:
  - 1 when rst=1 and state=IDLE.
  - 1 when rst=1 and the current cycle outputs the final bit of a frame.
  - 0 otherwise.
- Handshake: a word is accepted on a rising edge where din_valid=1 and din_ready=1.
  - din_valid while din_ready=0 is ignored; no data is lost because upstream holds din.
- States:
  - IDLE: x=0, x_valid=0, busy=0.
    - On accept: load shift register, counter=0, go to SHIFT.
  - SHIFT: x = current bit (MSB or LSB of shift register per MSB_FIRST); x_valid=1, busy=1.
    - Shift one position per cycle; counter increments.
    - On counter=WIDTH-1 (final data bit):
      - with parity compiled in, go to PARITY;
      - otherwise assert frame_done. If accepting a new word this cycle, reload and stay in SHIFT with counter=0; else go to IDLE.
  - PARITY (feature only): x=parity bit, x_valid=1, busy=1, frame_done=1.
    - Same accept/reload-or-IDLE rule as the final data bit.
- Latency: first bit of a word appears on x the cycle after the accepting edge.
- Frame length and back-to-back timing:
  - A frame occupies exactly WIDTH cycles, or WIDTH+1 with parity.
  - Back-to-back frames produce a continuous x_valid=1 stream with no gap cycle.
- x, x_valid, busy and frame_done are registered outputs: no combinational path from din/din_valid.
- Boundary conditions:
  - Reset mid-frame: frame is aborted, nothing is retransmitted, and x drops to 0 asynchronously.
  - din_valid=1 in the same cycle reset releases: not accepted, because din_ready is still 0 at that edge.
  - din_valid held continuously: frames are sent back-to-back indefinitely.
  - The counter must not wrap beyond WIDTH-1.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined:
  - PARITY state is compiled in.
  - After the last data bit, one extra bit equal to the even parity of the word (XOR of all din bits, captured at accept) is sent.
  - Frame length is WIDTH+1; frame_done and the reload opportunity move to the parity cycle.
- Undefined:
  - No PARITY state, frame length is WIDTH, and frame_done is on the last data bit.

Test Plan:
- Reset: hold rst=0 for 3 cycles with din_valid=1.
  - Expect x=0, x_valid=0, busy=0, din_ready=0.
  - Release rst: din_ready=1 in the same cycle; first accept occurs on the next edge.
- Single frame: WIDTH=10, MSB_FIRST=1, din=10'b0101011001.
  - Expect x = 0,1,0,1,0,1,1,0,0,1 on 10 consecutive cycles, x_valid=1 throughout, frame_done only on the 10th.
  - Then x=0, x_valid=0.
  - Detector downstream must output 0,0,0,1,0,1,1,1,0,0.
- LSB order: WIDTH=8, MSB_FIRST=0, din=8'hA3.
  - Expect x = 1,1,0,0,0,1,0,1.
- Back-to-back: WIDTH=8, din_valid held at 1, words 8'hFF then 8'h00.
  - Expect 16 consecutive x_valid=1 cycles: eight 1s then eight 0s.
  - frame_done on cycles 8 and 16; din_ready high on cycle 8.
- Mid-frame reset: WIDTH=8, din=8'hFF; assert rst=0 asynchronously during bit 4.
  - x=0 immediately; after release the block is in IDLE and no residual bits are sent.
- Parity (BIT_SERIALIZER_PARITY_EN defined): WIDTH=10, din=10'b0101011001.
  - Expect 11 bits, the 11th = 1 (five 1s); frame_done on cycle 11.
